// File: rtl/mp64_tile_extbridge_if.sv
// rtl/mp64_tile_extbridge_if.sv - tile-port and memory-bus signal bundle for the external tile bridge
interface mp64_tile_extbridge_if;
   logic         ext_tile_req;
   logic [63:0]  ext_tile_addr;
   logic         ext_tile_wen;
   logic [511:0] ext_tile_wdata;
   logic [511:0] ext_tile_rdata;
   logic         ext_tile_ack;
   logic         bus_valid;
   logic [63:0]  bus_addr;
   logic         bus_wen;
   logic [63:0]  bus_wdata;
   logic         bus_ready;
   logic [63:0]  bus_rdata;
   logic         bus_err;

   // Bridge side: serves the tile request, drives the beat bus.
   modport slave (
      input  ext_tile_req, ext_tile_addr, ext_tile_wen, ext_tile_wdata,
      output ext_tile_rdata, ext_tile_ack,
      output bus_valid, bus_addr, bus_wen, bus_wdata,
      input  bus_ready, bus_rdata, bus_err
   );

   // Environment side: tile engine plus memory responder.
   modport master (
      output ext_tile_req, ext_tile_addr, ext_tile_wen, ext_tile_wdata,
      input  ext_tile_rdata, ext_tile_ack,
      input  bus_valid, bus_addr, bus_wen, bus_wdata,
      output bus_ready, bus_rdata, bus_err
   );
endinterface

// File: rtl/mp64_tile_extbridge.sv
// rtl/mp64_tile_extbridge.sv - splits a 512-bit tile transfer into eight 64-bit bus beats
module mp64_tile_extbridge #(
   parameter int TIMEOUT = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   mp64_tile_extbridge_if.slave        tif,
   input  logic                        err_clr,
   output logic                        busy,
   output logic [1:0]                  err_status
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BEAT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [63:6]    base_q, base_d;
   logic           wen_q, wen_d;
   logic [511:0]   wdata_q, wdata_d;
   logic [2:0]     k_q, k_d;
   logic [TW-1:0]  tcnt_q, tcnt_d;
   logic [511:0]   rdata_q, rdata_d;
   logic [1:0]     err_q, err_d;

   logic           unused_addr_lsb;
   assign unused_addr_lsb = ^tif.ext_tile_addr[5:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         k_q     <= '0;
         tcnt_q  <= '0;
         rdata_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         k_q     <= k_d;
         tcnt_q  <= tcnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      wen_d   = wen_q;
      wdata_d = wdata_q;
      k_d     = k_q;
      tcnt_d  = tcnt_q;
      rdata_d = rdata_q;
      // Clear first so an error event in the same cycle re-sets its bit.
      err_d   = err_clr ? 2'b00 : err_q;

      unique case (state_q)
         S_IDLE: begin
            if (tif.ext_tile_req) begin
               base_d  = tif.ext_tile_addr[63:6];
               wen_d   = tif.ext_tile_wen;
               wdata_d = tif.ext_tile_wdata;
               k_d     = 3'd0;
               tcnt_d  = '0;
               if (!tif.ext_tile_wen) begin
                  rdata_d = '0;
               end
               state_d = S_BEAT;
            end
         end
         S_BEAT: begin
            // A ready in the final waiting cycle takes precedence over the timeout.
            if (tif.bus_ready) begin
               if (tif.bus_err) begin
                  err_d[0] = 1'b1;
                  state_d  = S_RESP;
               end else begin
                  if (!wen_q) begin
                     rdata_d[{k_q, 6'b0} +: 64] = tif.bus_rdata;
                  end
                  tcnt_d = '0;
                  if (k_q == 3'd7) begin
                     state_d = S_RESP;
                  end else begin
                     k_d = k_q + 3'd1;
                  end
               end
            end else if (tcnt_q == TLAST) begin
               err_d[1] = 1'b1;
               state_d  = S_RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   logic         bus_valid_o;
   logic [63:0]  bus_addr_o;
   logic         bus_wen_o;
   logic [63:0]  bus_wdata_o;
   logic         ack_o;

   always_comb begin
      bus_valid_o = 1'b0;
      bus_addr_o  = '0;
      bus_wen_o   = 1'b0;
      bus_wdata_o = '0;
      ack_o       = 1'b0;
      if (state_q == S_BEAT) begin
         bus_valid_o = 1'b1;
         bus_addr_o  = {base_q, k_q, 3'b000};
         bus_wen_o   = wen_q;
         bus_wdata_o = wen_q ? wdata_q[{k_q, 6'b0} +: 64] : 64'd0;
      end
      if (state_q == S_RESP) begin
         ack_o = 1'b1;
      end
   end

   assign tif.bus_valid      = bus_valid_o;
   assign tif.bus_addr       = bus_addr_o;
   assign tif.bus_wen        = bus_wen_o;
   assign tif.bus_wdata      = bus_wdata_o;
   assign tif.ext_tile_ack   = ack_o;
   assign tif.ext_tile_rdata = rdata_q;
   assign busy               = (state_q != S_IDLE);
   assign err_status         = err_q;
endmodule

// File: tb/tb_mp64_tile_extbridge.sv
// tb/tb_mp64_tile_extbridge.sv - scoreboard bench for the external tile bridge
`timescale 1ns/1ps
module tb_mp64_tile_extbridge;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       err_clr;
   logic       busy;
   logic [1:0] err_status;

   mp64_tile_extbridge_if bif();

   mp64_tile_extbridge #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .tif        (bif.slave),
      .err_clr    (err_clr),
      .busy       (busy),
      .err_status (err_status)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
   } beat_t;

   typedef struct {
      logic [511:0] rdata;
      logic [1:0]   err;
      int           lat;
   } resp_t;

   beat_t        exp_beats[$];
   resp_t        exp_resps[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           req_cyc = 0;
   int           drop_at = -1;
   bit           hold_extra = 1'b0;
   int           hold_n = 0;
   int           wait_cnt = 0;
   bit           err_en = 1'b0;
   int           err_beat = 0;
   logic [63:0]  rd_base = '0;
   int           ack_count = 0;
   int           last_ack_cyc = 0;
   int           prev_ack_cyc = 0;
   logic         prev_stall = 1'b0;
   logic [63:0]  prev_addr = '0;
   logic [63:0]  prev_wdata = '0;
   logic [511:0] model_rdata = '0;

   task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      beat_t b;
      resp_t r;
      int    k;
      @(negedge clk);
      cyc++;
      err_clr = 1'b0;
      if (cyc == drop_at) bif.ext_tile_req = 1'b0;
      if (bif.bus_valid) begin
         k             = int'(bif.bus_addr[5:3]);
         bif.bus_ready = (wait_cnt >= hold_n);
         bif.bus_rdata = rd_base + 64'(k);
         bif.bus_err   = bif.bus_ready && err_en && (k == err_beat);
      end else begin
         bif.bus_ready = 1'b0;
         bif.bus_rdata = '0;
         bif.bus_err   = 1'b0;
      end
      if (bif.bus_valid && prev_stall) begin
         check_eq("stall_addr", 512'(bif.bus_addr), 512'(prev_addr));
         check_eq("stall_wdata", 512'(bif.bus_wdata), 512'(prev_wdata));
      end
      if (bif.bus_valid && bif.bus_ready) begin
         check_eq("beat_expected", 512'(exp_beats.size() > 0), 512'd1);
         if (exp_beats.size() > 0) begin
            b = exp_beats.pop_front();
            check_eq("beat_addr", 512'(bif.bus_addr), 512'(b.addr));
            check_eq("beat_wen", 512'(bif.bus_wen), 512'(b.wen));
            check_eq("beat_wdata", 512'(bif.bus_wdata), 512'(b.wdata));
         end
      end
      prev_stall = bif.bus_valid && !bif.bus_ready;
      prev_addr  = bif.bus_addr;
      prev_wdata = bif.bus_wdata;
      wait_cnt   = (bif.bus_valid && !bif.bus_ready) ? wait_cnt + 1 : 0;
      if (bif.ext_tile_ack) begin
         ack_count++;
         prev_ack_cyc = last_ack_cyc;
         last_ack_cyc = cyc;
         check_eq("valid_in_resp", 512'(bif.bus_valid), 512'd0);
         check_eq("resp_expected", 512'(exp_resps.size() > 0), 512'd1);
         if (exp_resps.size() > 0) begin
            r = exp_resps.pop_front();
            check_eq("resp_rdata", bif.ext_tile_rdata, r.rdata);
            check_eq("resp_err", 512'(err_status), 512'(r.err));
            check_eq("resp_latency", 512'(cyc - req_cyc), 512'(r.lat));
         end
         if (hold_extra) begin
            hold_extra = 1'b0;
            req_cyc    = cyc + 1;
            drop_at    = cyc + 2;
         end else begin
            bif.ext_tile_req = 1'b0;
         end
      end
   endtask

   task automatic push_xfer(input logic [63:0] addr, input logic wen, input logic [511:0] wdata,
                            input int n_issued, input int n_ok, input logic [1:0] err, input int lat);
      beat_t b;
      resp_t r;
      for (int k = 0; k < n_issued; k++) begin
         b.addr  = {addr[63:6], 3'(k), 3'b000};
         b.wen   = wen;
         b.wdata = wen ? wdata[k*64 +: 64] : 64'd0;
         exp_beats.push_back(b);
      end
      if (!wen) begin
         model_rdata = '0;
         for (int k = 0; k < n_ok; k++) model_rdata[k*64 +: 64] = rd_base + 64'(k);
      end
      r.rdata = model_rdata;
      r.err   = err;
      r.lat   = lat;
      exp_resps.push_back(r);
   endtask

   task automatic start_xfer(input logic [63:0] addr, input logic wen, input logic [511:0] wdata);
      bif.ext_tile_req   = 1'b1;
      bif.ext_tile_addr  = addr;
      bif.ext_tile_wen   = wen;
      bif.ext_tile_wdata = wdata;
      req_cyc            = cyc;
   endtask

   task automatic wait_acks(input int target, input int budget);
      int n = 0;
      while (ack_count < target && n < budget) begin
         step();
         n++;
      end
      check_eq("ack_in_time", 512'(ack_count >= target), 512'd1);
   endtask

   initial begin
      logic [511:0] wd;
      int           n;
      rst = 1'b1;
      err_clr = 1'b0;
      bif.ext_tile_req = 1'b0;
      bif.ext_tile_addr = '0;
      bif.ext_tile_wen = 1'b0;
      bif.ext_tile_wdata = '0;
      bif.bus_ready = 1'b0;
      bif.bus_rdata = '0;
      bif.bus_err = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 512'(bif.bus_valid), 512'd0);
      check_eq("rst_ack", 512'(bif.ext_tile_ack), 512'd0);
      check_eq("rst_busy", 512'(busy), 512'd0);
      check_eq("rst_err", 512'(err_status), 512'd0);
      check_eq("rst_rdata", bif.ext_tile_rdata, 512'd0);
      check_eq("rst_addr", 512'(bif.bus_addr), 512'd0);
      rst = 1'b0;
      repeat (2) step();

      // Write, ready always high
      for (int k = 0; k < 8; k++) wd[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k);
      hold_n = 0;
      push_xfer(64'h1000_0047, 1'b1, wd, 8, 8, 2'b00, 9);
      start_xfer(64'h1000_0047, 1'b1, wd);
      wait_acks(1, 40);
      repeat (2) step();

      // Read with alternating ready
      rd_base = 64'hA0;
      hold_n = 1;
      push_xfer(64'h2000_0000, 1'b0, '0, 8, 8, 2'b00, 17);
      start_xfer(64'h2000_0000, 1'b0, {16{32'hDEAD_BEEF}});
      wait_acks(2, 60);
      repeat (2) step();

      // Read with bus error on beat 3
      rd_base = 64'hB0;
      hold_n = 0;
      err_en = 1'b1;
      err_beat = 3;
      push_xfer(64'h3000_0100, 1'b0, '0, 4, 3, 2'b01, 5);
      start_xfer(64'h3000_0100, 1'b0, '0);
      wait_acks(3, 40);
      err_en = 1'b0;
      repeat (3) step();
      check_eq("err_sticky", 512'(err_status), 512'd1);
      err_clr = 1'b1;
      step();
      check_eq("err_cleared", 512'(err_status), 512'd0);

      // Timeout on beat 0
      hold_n = 1000;
      push_xfer(64'h4000_0000, 1'b0, '0, 0, 0, 2'b10, TO + 1);
      start_xfer(64'h4000_0000, 1'b0, '0);
      wait_acks(4, 60);
      hold_n = 0;
      repeat (4) step();
      check_eq("timeout_single_ack", 512'(ack_count), 512'd4);
      check_eq("timeout_sticky", 512'(err_status), 512'd2);
      err_clr = 1'b1;
      step();
      check_eq("timeout_cleared", 512'(err_status), 512'd0);

      // Ready arrives on the last waiting cycle of every beat
      rd_base = 64'hC0;
      hold_n = TO - 1;
      push_xfer(64'h5000_0040, 1'b0, '0, 8, 8, 2'b00, 8 * TO + 1);
      start_xfer(64'h5000_0040, 1'b0, '0);
      wait_acks(5, 200);
      hold_n = 0;
      repeat (2) step();
      check_eq("late_ready_no_err", 512'(err_status), 512'd0);

      // Request held one cycle past ack: exactly one more burst
      rd_base = 64'hD0;
      push_xfer(64'h6000_0000, 1'b0, '0, 8, 8, 2'b00, 9);
      push_xfer(64'h6000_0000, 1'b0, '0, 8, 8, 2'b00, 9);
      hold_extra = 1'b1;
      start_xfer(64'h6000_0000, 1'b0, '0);
      wait_acks(7, 60);
      check_eq("ack_gap", 512'(last_ack_cyc - prev_ack_cyc), 512'd10);
      repeat (12) step();
      check_eq("no_third_burst", 512'(exp_beats.size()), 512'd0);

      // Reset in the middle of a write at beat 5
      for (int k = 0; k < 8; k++) wd[k*64 +: 64] = {$urandom, $urandom};
      push_xfer(64'h7000_0000, 1'b1, wd, 6, 6, 2'b00, 0);
      void'(exp_resps.pop_back());
      start_xfer(64'h7000_0000, 1'b1, wd);
      n = 0;
      step();
      while (!(bif.bus_valid && bif.bus_addr[5:3] == 3'd5) && n < 20) begin
         step();
         n++;
      end
      check_eq("reached_beat5", 512'(bif.bus_valid && bif.bus_addr[5:3] == 3'd5), 512'd1);
      rst = 1'b1;
      bif.ext_tile_req = 1'b0;
      #1;
      check_eq("midrst_valid", 512'(bif.bus_valid), 512'd0);
      check_eq("midrst_busy", 512'(busy), 512'd0);
      check_eq("midrst_ack", 512'(bif.ext_tile_ack), 512'd0);
      check_eq("midrst_rdata", bif.ext_tile_rdata, 512'd0);
      check_eq("midrst_beats_done", 512'(exp_beats.size()), 512'd0);
      model_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      prev_stall = 1'b0;
      wait_cnt = 0;
      step();
      rd_base = 64'hE0;
      push_xfer(64'h7000_0200, 1'b0, '0, 8, 8, 2'b00, 9);
      start_xfer(64'h7000_0200, 1'b0, '0);
      wait_acks(8, 40);
      repeat (4) step();
      check_eq("final_beats_empty", 512'(exp_beats.size()), 512'd0);
      check_eq("final_resps_empty", 512'(exp_resps.size()), 512'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mp64_tile_extbridge.md
Name: mp64_tile_extbridge

Overview:
- Downstream stage of the tile engine's external tile port.
- Converts one 512-bit tile read or write request (ext_tile_*) into eight sequential 64-bit beats on the system memory bus.
- Returns the assembled 512-bit read data with a one-cycle ack.
- Gives TLOAD/TSTORE to external memory a defined latency and error model: bus error and per-beat timeout.

Parameters:
TIMEOUT, 1024, max cycles a single beat may wait with bus_valid high and no bus_ready before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ext_tile_req  in  1  request; level, held by tile engine until it samples ext_tile_ack
ext_tile_addr  in  64  tile byte address; bits [5:0] ignored
ext_tile_wen  in  1  1=write tile, 0=read tile
ext_tile_wdata  in  512  write tile data
ext_tile_rdata  out  512  read tile data; valid in ack cycle and held until next read starts
ext_tile_ack  out  1  one-cycle completion pulse (also on abort)
bus_valid  out  1  beat request
bus_addr  out  64  beat byte address
bus_wen  out  1  beat write enable
bus_wdata  out  64  beat write data
bus_ready  in  1  beat accepted/completed this cycle (read data valid same cycle)
bus_rdata  in  64  beat read data
bus_err  in  1  qualified by bus_ready; beat failed
err_clr  in  1  clears err_status
busy  out  1  high in any state other than IDLE
err_status  out  2  sticky: bit0=bus error, bit1=timeout

Behaviour:
- Reset (asynchronous assert, release synchronous to clk):
  - State IDLE; beat counter 0; timeout counter 0.
  - All outputs 0, including ext_tile_rdata and err_status.
  - Reset mid-transfer drops bus_valid immediately; no ack issued.
- States: IDLE, BEAT, RESP.
- IDLE:
  - If ext_tile_req=1, latch addr {ext_tile_addr[63:6],6'b0}, wen and wdata.
  - Clear beat counter k=0; for reads, clear ext_tile_rdata to 0. Go to BEAT.
  - Otherwise ext_tile_* inputs are ignored. The request is never sampled outside IDLE.
- BEAT:
  - bus_valid=1.
  - bus_addr = {base[63:6], k[2:0], 3'b000}.
  - bus_wen = latched wen.
  - bus_wdata = wdata[k*64 +: 64]; 0 on reads.
  - Outputs are stable while waiting for bus_ready.
  - bus_ready=1, bus_err=0:
    - Read: ext_tile_rdata[k*64 +: 64] <= bus_rdata.
    - If k==7 go to RESP; else k<=k+1, timeout counter<=0, stay in BEAT. Back-to-back beats allowed: bus_valid stays high.
  - bus_ready=1, bus_err=1: set err_status[0]; skip remaining beats; go to RESP.
  - bus_ready=0: timeout counter +1. When it reaches TIMEOUT-1 with ready still low, set err_status[1] and go to RESP.
  - Timeout boundary: beat aborts on its TIMEOUT-th waiting cycle. A ready arriving in that same cycle wins: the beat completes normally.
- RESP:
  - bus_valid=0; ext_tile_ack=1 for exactly one cycle; next state IDLE.
  - Requester drops req at the edge where it samples ack, so the following IDLE cycle sees req=0.
- Latency: a fault-free transfer with bus_ready always high takes 1 (IDLE accept) + 8 beats + 1 (RESP).
  - Ack is asserted 9 cycles after the first cycle req is seen high.
  - Minimum gap between acks is 10 cycles.
- Aborted read: rdata beats not yet transferred remain 0.
- err_status:
  - Sticky until err_clr=1, which clears it on the next edge.
  - If an error event and err_clr occur in the same cycle, the error set wins.
- busy = (state != IDLE).

Test Plan:
- Write, bus_ready tied 1, addr=0x1000_0047, wdata beats = 64'h1111..1 x k (k=0..7):
  - bus_addr sequence 0x1000_0040, 0x...48 ... 0x...78 with matching bus_wdata.
  - ack exactly 9 cycles after req; err_status=0.
- Read, bus_ready alternating 0/1, bus_rdata = 0xA0+k on beat k:
  - ext_tile_rdata[k*64+:64] = 0xA0+k for all k at ack.
  - bus_addr/bus_valid stable during stalls.
- Read with bus_err on beat 3:
  - Beats 0-2 stored, beats 3-7 read 0; no beat 4 issued.
  - ack one cycle later; err_status=2'b01.
  - err_clr -> err_status=0.
- TIMEOUT=16, bus_ready held 0 on beat 0:
  - Abort after 16 waiting cycles; err_status=2'b10; ack pulsed once.
  - Repeat with ready arriving on the 16th cycle -> no error, transfer continues.
- Reset asserted mid-write at beat 5:
  - bus_valid, busy and ack go 0 immediately.
  - After release, a new read completes normally with fresh data.
- req held high across ack for one extra cycle:
  - Second transfer starts only from IDLE, i.e. one new 8-beat burst. No beat is issued in the RESP cycle.
